// File: rtl/transmit_mcast_pkg.sv
// Shared definitions for transmit_mcast: framing tags, FSM encoding and the
// lowest-set-bit helper used to walk the destination bitmap.
package transmit_mcast_pkg;

  localparam logic [2:0] TAG_HEAD = 3'b101;
  localparam logic [2:0] TAG_MID  = 3'b100;
  localparam logic [2:0] TAG_TAIL = 3'b110;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DECIDE    = 3'd1;
  localparam logic [2:0] ST_RULE      = 3'd2;
  localparam logic [2:0] ST_WAIT_TX   = 3'd3;
  localparam logic [2:0] ST_SEND_FIFO = 3'd4;
  localparam logic [2:0] ST_SEND_BUF  = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;
  localparam logic [2:0] ST_DROP      = 3'd7;

  // Index of the lowest set bit; 0 when v is empty (callers never ask then).
  function automatic int lowest_set(input logic [63:0] v);
    int idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/transmit_mcast_sync_fifo_sa.sv
// Show-ahead synchronous FIFO: o_q shows the head word while not empty, a pop
// takes effect on the next edge; pops when empty and pushes when full are ignored.
module sync_fifo_sa #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_q,
  output logic [AW:0]   o_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_cnt != (AW+1)'(DEPTH));
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_q   = r_mem[r_rptr];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/transmit_mcast.sv
// Multicast transmit stage: one rule pulse plus one packet copy per bitmap port;
// the first copy streams from the packet FIFO, later copies replay from a buffer.
module transmit_mcast
  import transmit_mcast_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 139,
  parameter int FIFO_AW   = 8,
  parameter int BUF_AW    = 7,
  parameter int RULE_W    = 30,
  parameter int RULE_HI   = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 action_valid,
  input  logic [NUM_PORTS:0]   action,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    pkt,
  output logic                 um2cdp_rule_wrreq,
  output logic [RULE_W-1:0]    um2cdp_rule,
  output logic                 um2cdp_data_valid,
  output logic [DATA_W-1:0]    um2cdp_data,
  input  logic [4:0]           cdp2um_rule_usedw,
  input  logic                 cdp2um_tx_enable,
  output logic [FIFO_AW-1:0]   transmit_fifo_usedw,
  output logic [15:0]          drop_cnt
);

  localparam int BUF_DEPTH = 1 << BUF_AW;
  localparam int unsigned RULE_HI_U = RULE_HI;

  logic [DATA_W-1:0]    w_pkt_q;
  logic [FIFO_AW:0]     w_pkt_cnt;
  logic [NUM_PORTS:0]   w_act_q;
  logic [FIFO_AW:0]     w_act_cnt;
  logic                 w_pkt_empty;
  logic                 w_act_empty;
  logic                 w_pkt_pop;
  logic                 w_act_pop;
  logic                 w_tail;
  logic                 w_rule_ok;
  logic                 w_trunc_now;
  logic                 w_buf_wr;
  logic [NUM_PORTS-1:0] w_lsb;

  logic [2:0]           r_state;
  logic [NUM_PORTS-1:0] r_pend;
  logic [NUM_PORTS-1:0] r_cur;
  logic                 r_discard;
  logic                 r_first;
  logic                 r_trunc;
  logic [BUF_AW:0]      r_waddr;
  logic [BUF_AW:0]      r_len;
  logic [BUF_AW-1:0]    r_raddr;
  logic [BUF_AW:0]      r_rd_cnt;
  logic                 r_pf;
  logic [15:0]          r_drop_cnt;
  logic                 r_rule_wrreq;
  logic [RULE_W-1:0]    r_rule;
  logic                 r_data_vld;
  logic [DATA_W-1:0]    r_data;
  logic [DATA_W-1:0]    r_buf [BUF_DEPTH];
  logic [DATA_W-1:0]    r_buf_q;

  sync_fifo_sa #(.W(DATA_W), .AW(FIFO_AW)) u_pkt_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (pkt_valid),
    .i_dat  (pkt),
    .i_pop  (w_pkt_pop),
    .o_q    (w_pkt_q),
    .o_cnt  (w_pkt_cnt)
  );

  sync_fifo_sa #(.W(NUM_PORTS+1), .AW(FIFO_AW)) u_act_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (action_valid),
    .i_dat  (action),
    .i_pop  (w_act_pop),
    .o_q    (w_act_q),
    .o_cnt  (w_act_cnt)
  );

  assign w_pkt_empty = (w_pkt_cnt == '0);
  assign w_act_empty = (w_act_cnt == '0);
  assign w_pkt_pop   = ((r_state == ST_SEND_FIFO) || (r_state == ST_DROP)) && !w_pkt_empty;
  assign w_act_pop   = (r_state == ST_IDLE) && !w_act_empty;
  assign w_tail      = (w_pkt_q[DATA_W-1 -: 3] == TAG_TAIL);
  assign w_rule_ok   = (32'(cdp2um_rule_usedw) <= RULE_HI_U);
  assign w_lsb       = NUM_PORTS'(1) << lowest_set(64'(r_pend));
  // Once the buffer is full the current word and everything after it are not kept.
  assign w_trunc_now = r_trunc || (r_waddr == (BUF_AW+1)'(BUF_DEPTH));
  assign w_buf_wr    = (r_state == ST_SEND_FIFO) && w_pkt_pop && (r_pend != '0) && !w_trunc_now;

  always_ff @(posedge clk) begin
    if (w_buf_wr) r_buf[r_waddr[BUF_AW-1:0]] <= w_pkt_q;
    r_buf_q <= r_buf[r_raddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pend       <= '0;
      r_cur        <= '0;
      r_discard    <= 1'b0;
      r_first      <= 1'b0;
      r_trunc      <= 1'b0;
      r_waddr      <= '0;
      r_len        <= '0;
      r_raddr      <= '0;
      r_rd_cnt     <= '0;
      r_pf         <= 1'b0;
      r_drop_cnt   <= '0;
      r_rule_wrreq <= 1'b0;
      r_rule       <= '0;
      r_data_vld   <= 1'b0;
      r_data       <= '0;
    end else begin
      r_rule_wrreq <= 1'b0;
      r_data_vld   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_act_empty) begin
            r_pend    <= w_act_q[NUM_PORTS-1:0];
            r_discard <= w_act_q[NUM_PORTS];
            r_state   <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          r_trunc <= 1'b0;
          r_waddr <= '0;
          if (r_discard || (r_pend == '0)) begin
            r_state <= ST_DROP;
          end else begin
            r_cur   <= w_lsb;
            r_pend  <= r_pend & ~w_lsb;
            r_first <= 1'b1;
            r_state <= ST_RULE;
          end
        end
        ST_RULE: begin
          if (w_rule_ok) begin
            r_rule_wrreq <= 1'b1;
            r_rule       <= RULE_W'(r_cur);
            r_state      <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (cdp2um_tx_enable) begin
            r_raddr  <= '0;
            r_rd_cnt <= '0;
            r_pf     <= 1'b0;
            r_state  <= r_first ? ST_SEND_FIFO : ST_SEND_BUF;
          end
        end
        ST_SEND_FIFO: begin
          if (!w_pkt_empty) begin
            r_data     <= w_pkt_q;
            r_data_vld <= 1'b1;
            if (r_pend != '0) begin
              if (w_trunc_now) r_trunc <= 1'b1;
              else             r_waddr <= r_waddr + (BUF_AW+1)'(1);
            end
            if (w_tail) begin
              if ((r_pend != '0) && !w_trunc_now) begin
                r_len   <= r_waddr + (BUF_AW+1)'(1);
                r_state <= ST_NEXT;
              end else begin
                if ((r_pend != '0) && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
                r_state <= ST_IDLE;
              end
            end
          end
        end
        ST_SEND_BUF: begin
          // First cycle only primes the registered buffer read.
          r_raddr <= r_raddr + BUF_AW'(1);
          if (!r_pf) begin
            r_pf <= 1'b1;
          end else begin
            r_data     <= r_buf_q;
            r_data_vld <= 1'b1;
            r_rd_cnt   <= r_rd_cnt + (BUF_AW+1)'(1);
            if (r_rd_cnt == r_len - (BUF_AW+1)'(1)) r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_pend != '0) begin
            r_cur   <= w_lsb;
            r_pend  <= r_pend & ~w_lsb;
            r_first <= 1'b0;
            r_state <= ST_RULE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!w_pkt_empty && w_tail) begin
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign um2cdp_rule_wrreq   = r_rule_wrreq;
  assign um2cdp_rule         = r_rule;
  assign um2cdp_data_valid   = r_data_vld;
  assign um2cdp_data         = r_data;
  assign drop_cnt            = r_drop_cnt;
  assign transmit_fifo_usedw = w_pkt_cnt[FIFO_AW] ? '1 : w_pkt_cnt[FIFO_AW-1:0];

endmodule

// File: tb/tb_transmit_mcast.sv
// Directed bench for transmit_mcast with a 4-word replay buffer so truncation is reachable.
module tb_transmit_mcast;
  import transmit_mcast_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         action_valid = 1'b0;
  logic [8:0]   action = '0;
  logic         pkt_valid = 1'b0;
  logic [138:0] pkt = '0;
  logic         um2cdp_rule_wrreq;
  logic [29:0]  um2cdp_rule;
  logic         um2cdp_data_valid;
  logic [138:0] um2cdp_data;
  logic [4:0]   cdp2um_rule_usedw = '0;
  logic         cdp2um_tx_enable = 1'b0;
  logic [7:0]   transmit_fifo_usedw;
  logic [15:0]  drop_cnt;

  transmit_mcast #(.BUF_AW(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .action_valid        (action_valid),
    .action              (action),
    .pkt_valid           (pkt_valid),
    .pkt                 (pkt),
    .um2cdp_rule_wrreq   (um2cdp_rule_wrreq),
    .um2cdp_rule         (um2cdp_rule),
    .um2cdp_data_valid   (um2cdp_data_valid),
    .um2cdp_data         (um2cdp_data),
    .cdp2um_rule_usedw   (cdp2um_rule_usedw),
    .cdp2um_tx_enable    (cdp2um_tx_enable),
    .transmit_fifo_usedw (transmit_fifo_usedw),
    .drop_cnt            (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]      act;
    int              nw;
    int              nr;
    logic [3:0][7:0] rules;
    int              copies;
    int              drop;
  } vec_t;

  localparam int NV = 6;
  vec_t         vt [NV];
  logic [29:0]  rq [$];
  logic [138:0] dq [$];
  int           n_pass = 0;
  int           n_total = 0;

  always @(negedge clk) begin
    if (um2cdp_rule_wrreq) rq.push_back(um2cdp_rule);
    if (um2cdp_data_valid) dq.push_back(um2cdp_data);
  end

  function automatic logic [138:0] gen_word(input int id, input int k, input int n);
    logic [2:0] tag;
    tag = (k == n - 1) ? TAG_TAIL : ((k == 0) ? TAG_HEAD : TAG_MID);
    return {tag, 8'(id), 8'(k), 120'(id * 1000 + k * 37 + 5)};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_act(input logic [8:0] a);
    @(posedge clk); #1;
    action_valid = 1'b1;
    action = a;
    @(posedge clk); #1;
    action_valid = 1'b0;
  endtask

  task automatic push_words(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      pkt_valid = 1'b1;
      pkt = gen_word(id, k, n);
    end
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic wait_quiet(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (!um2cdp_rule_wrreq && !um2cdp_data_valid) quiet++;
      else quiet = 0;
      if (quiet >= 12) ok = 1'b1;
    end
  endtask

  // Counts words in dq that differ from copies of packet id, starting at index 0.
  function automatic int word_errs(input int id, input int n, input int copies);
    int e;
    e = 0;
    for (int i = 0; i < dq.size() && i < n * copies; i++)
      if (dq[i] !== gen_word(id, i % n, n)) e++;
    return e;
  endfunction

  initial begin
    bit ok;
    vt[0] = '{act: 9'h004, nw: 4, nr: 1, rules: {8'h00, 8'h00, 8'h00, 8'h04}, copies: 1, drop: 0};
    vt[1] = '{act: 9'h0A5, nw: 3, nr: 4, rules: {8'h80, 8'h20, 8'h04, 8'h01}, copies: 4, drop: 0};
    vt[2] = '{act: 9'h103, nw: 5, nr: 0, rules: {8'h00, 8'h00, 8'h00, 8'h00}, copies: 0, drop: 1};
    vt[3] = '{act: 9'h003, nw: 6, nr: 1, rules: {8'h00, 8'h00, 8'h00, 8'h01}, copies: 1, drop: 2};
    vt[4] = '{act: 9'h0C0, nw: 4, nr: 2, rules: {8'h00, 8'h00, 8'h80, 8'h40}, copies: 2, drop: 2};
    vt[5] = '{act: 9'h000, nw: 2, nr: 0, rules: {8'h00, 8'h00, 8'h00, 8'h00}, copies: 0, drop: 3};

    repeat (3) @(negedge clk);
    check("reset wrreq", 160'(um2cdp_rule_wrreq), 160'(0));
    check("reset valid", 160'(um2cdp_data_valid), 160'(0));
    check("reset data", 160'(um2cdp_data), 160'(0));
    check("reset rule", 160'(um2cdp_rule), 160'(0));
    check("reset drop_cnt", 160'(drop_cnt), 160'(0));
    check("reset usedw", 160'(transmit_fifo_usedw), 160'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    cdp2um_tx_enable = 1'b1;

    for (int v = 0; v < NV; v++) begin
      rq.delete();
      dq.delete();
      push_act(vt[v].act);
      push_words(100 + v, vt[v].nw);
      wait_quiet(ok);
      check($sformatf("v%0d quiet", v), 160'(ok), 160'(1));
      check($sformatf("v%0d nrules", v), 160'(rq.size()), 160'(vt[v].nr));
      for (int i = 0; i < vt[v].nr && i < rq.size(); i++)
        check($sformatf("v%0d rule%0d", v, i), 160'(rq[i]), 160'(vt[v].rules[i]));
      check($sformatf("v%0d nwords", v), 160'(dq.size()), 160'(vt[v].nw * vt[v].copies));
      check($sformatf("v%0d word errs", v), 160'(word_errs(100 + v, vt[v].nw, vt[v].copies)), 160'(0));
      check($sformatf("v%0d drop_cnt", v), 160'(drop_cnt), 160'(vt[v].drop));
      check($sformatf("v%0d usedw", v), 160'(transmit_fifo_usedw), 160'(0));
    end

    // Rule backpressure at the 31/30 boundary, then tx_enable holding data back.
    rq.delete();
    dq.delete();
    cdp2um_rule_usedw = 5'd31;
    cdp2um_tx_enable = 1'b0;
    push_act(9'h002);
    push_words(200, 2);
    repeat (10) @(negedge clk);
    check("bp no rule at 31", 160'(rq.size()), 160'(0));
    cdp2um_rule_usedw = 5'd30;
    repeat (5) @(negedge clk);
    check("bp rule count at 30", 160'(rq.size()), 160'(1));
    check("bp rule value", 160'((rq.size() > 0) ? rq[0] : 30'h3FFFFFFF), 160'(30'h2));
    repeat (5) @(negedge clk);
    check("tx stall words", 160'(dq.size()), 160'(0));
    check("tx stall valid", 160'(um2cdp_data_valid), 160'(0));
    cdp2um_tx_enable = 1'b1;
    cdp2um_rule_usedw = 5'd0;
    wait_quiet(ok);
    check("bp quiet", 160'(ok), 160'(1));
    check("bp nwords", 160'(dq.size()), 160'(2));
    check("bp word errs", 160'(word_errs(200, 2, 1)), 160'(0));

    // Packet FIFO is read once per multicast packet.
    rq.delete();
    dq.delete();
    cdp2um_tx_enable = 1'b0;
    push_act(9'h006);
    push_words(300, 3);
    push_words(301, 2);
    repeat (5) @(negedge clk);
    check("mc usedw before", 160'(transmit_fifo_usedw), 160'(5));
    cdp2um_tx_enable = 1'b1;
    wait_quiet(ok);
    check("mc quiet", 160'(ok), 160'(1));
    check("mc usedw after", 160'(transmit_fifo_usedw), 160'(2));
    check("mc nrules", 160'(rq.size()), 160'(2));
    check("mc nwords", 160'(dq.size()), 160'(6));
    check("mc word errs", 160'(word_errs(300, 3, 2)), 160'(0));
    rq.delete();
    dq.delete();
    push_act(9'h001);
    wait_quiet(ok);
    check("mc tail usedw", 160'(transmit_fifo_usedw), 160'(0));
    check("mc tail word errs", 160'(word_errs(301, 2, 1)), 160'(0));
    check("mc tail nwords", 160'(dq.size()), 160'(2));

    // Action waiting on an empty packet FIFO must stall without valid.
    rq.delete();
    dq.delete();
    push_act(9'h008);
    repeat (20) @(negedge clk);
    check("stall nrules", 160'(rq.size()), 160'(1));
    check("stall nwords", 160'(dq.size()), 160'(0));
    push_words(400, 3);
    wait_quiet(ok);
    check("stall quiet", 160'(ok), 160'(1));
    check("stall nwords after", 160'(dq.size()), 160'(3));
    check("stall word errs", 160'(word_errs(400, 3, 1)), 160'(0));

    // Async reset during the first replayed word.
    rq.delete();
    dq.delete();
    push_act(9'h003);
    push_words(500, 4);
    for (int c = 0; c < 500 && dq.size() < 5; c++) @(negedge clk);
    check("rst reached replay", 160'(dq.size()), 160'(5));
    check("rst pre valid", 160'(um2cdp_data_valid), 160'(1));
    #1;
    reset = 1'b0;
    #1;
    check("rst valid", 160'(um2cdp_data_valid), 160'(0));
    check("rst data", 160'(um2cdp_data), 160'(0));
    check("rst wrreq", 160'(um2cdp_rule_wrreq), 160'(0));
    check("rst drop_cnt", 160'(drop_cnt), 160'(0));
    check("rst usedw", 160'(transmit_fifo_usedw), 160'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    rq.delete();
    dq.delete();
    push_act(9'h010);
    push_words(600, 3);
    wait_quiet(ok);
    check("post rst quiet", 160'(ok), 160'(1));
    check("post rst nrules", 160'(rq.size()), 160'(1));
    check("post rst rule", 160'((rq.size() > 0) ? rq[0] : 30'h3FFFFFFF), 160'(30'h10));
    check("post rst nwords", 160'(dq.size()), 160'(3));
    check("post rst word errs", 160'(word_errs(600, 3, 1)), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
